sum_fxp_serial: RTL and testbench

SUM_FXP_SERIAL -- requirements
Module: sum_fxp_serial

---
 rtl/sum_fxp_serial.sv | 86 ++++++++
 tb/tb_sum_fxp_serial.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_fxp_serial.sv
// Serial frame accumulator: sums `size` signed fixed-point samples per frame
// and presents each frame sum from a register with a valid/ready handshake.
module sum_fxp_serial #(
    parameter int size   = 4,
    parameter int n_int  = 8,
    parameter int n_mant = 23
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [n_int+n_mant:0]   in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [n_int+n_mant:0]   out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy
);

    localparam int W    = n_int + n_mant + 1;
    localparam int CntW = (size > 1) ? $clog2(size) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(size - 1);

    generate
        if (size < 1) begin : g_bad_size
            $error("sum_fxp_serial: size must be at least 1");
        end
    endgenerate

    typedef enum logic {StAcc, StHold} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic signed [W-1:0]   acc_q, acc_d;
    logic signed [W-1:0]   out_data_q, out_data_d;
    logic signed [W-1:0]   sum_next;
    logic                  take;

    // Next-state and handshake outputs; a sample accepted in HOLD opens the next frame.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;

        in_ready  = !rst && ((state_q == StAcc) || out_ready);
        out_valid = (state_q == StHold);
        busy      = (cnt_q != '0);
        take      = in_valid && in_ready;

        // First sample of a frame loads; later ones add with natural wrap-around.
        sum_next = (cnt_q == '0) ? in_data : acc_q + in_data;

        if (state_q == StHold && out_ready) begin
            state_d = StAcc;
        end

        if (take) begin
            if (cnt_q == CntMax) begin
                out_data_d = sum_next;
                cnt_d      = '0;
                state_d    = StHold;
            end else begin
                acc_d = sum_next;
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // State registers with synchronous reset; a reset discards partial and pending sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StAcc;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;

endmodule

// File: tb/tb_sum_fxp_serial.sv
// Directed and stall-randomised bench for sum_fxp_serial at W=8 (size=4 and size=1).
module tb_sum_fxp_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready4, out_valid4, busy4;
    logic [7:0] out_data4;
    logic       in_ready1, out_valid1, busy1;
    logic [7:0] out_data1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state for the stall-randomised phase.
    logic [7:0] m_acc4;
    int         m_cnt4;
    logic [7:0] q4[$];
    logic [7:0] q1[$];
    int         n_out4, n_out1;

    always #5 clk = ~clk;

    sum_fxp_serial #(.size(4), .n_int(3), .n_mant(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .busy      (busy4)
    );

    sum_fxp_serial #(.size(1), .n_int(3), .n_mant(4)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .out_data  (out_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .busy      (busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample with out_ready=1, expecting it to be accepted.
    task automatic feed(input logic [7:0] d);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        #1;
        check("feed_in_ready", {31'b0, in_ready4}, 32'd1);
        tick();
    endtask

    // Full frame, then check the sum is shown for exactly one cycle.
    task automatic frame_expect(input string tag, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] e,
                                input logic [7:0] sum);
        feed(a);
        check({tag, "_busy"}, {31'b0, busy4}, 32'd1);
        feed(b);
        feed(c);
        feed(e);
        in_valid = 1'b0;
        #1;
        check({tag, "_valid"}, {31'b0, out_valid4}, 32'd1);
        check({tag, "_data"}, {24'b0, out_data4}, {24'b0, sum});
        tick();
        check({tag, "_one_cycle"}, {31'b0, out_valid4}, 32'd0);
    endtask

    // One stall-randomised cycle, scoring both instances against the model.
    task automatic rand_cycle(input logic v, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        if (out_valid4 && out_ready) begin
            check("d4_sum_pending", {31'b0, q4.size() != 0}, 32'd1);
            if (q4.size() != 0) check("d4_sum", {24'b0, out_data4}, {24'b0, q4.pop_front()});
            n_out4++;
        end
        if (in_valid && in_ready4) begin
            m_acc4 = (m_cnt4 == 0) ? in_data : m_acc4 + in_data;
            m_cnt4++;
            if (m_cnt4 == 4) begin
                q4.push_back(m_acc4);
                m_cnt4 = 0;
            end
        end
        if (out_valid1 && out_ready) begin
            check("d1_sum_pending", {31'b0, q1.size() != 0}, 32'd1);
            if (q1.size() != 0) check("d1_sum", {24'b0, out_data1}, {24'b0, q1.pop_front()});
            n_out1++;
        end
        if (in_valid && in_ready1) q1.push_back(in_data);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'd5;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", {31'b0, in_ready4}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid4}, 32'd0);
        check("rst_out_data", {24'b0, out_data4}, 32'd0);
        check("rst_busy", {31'b0, busy4}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("idle_in_ready", {31'b0, in_ready4}, 32'd1);

        // 16+32-8+4 = 44; 100+100 wraps to 0xC8; -128-1 wraps to 0x7F.
        frame_expect("f44", 8'd16, 8'd32, 8'hF8, 8'd4, 8'd44);
        frame_expect("fwrap", 8'd100, 8'd100, 8'd0, 8'd0, 8'hC8);
        frame_expect("fneg", 8'h80, 8'hFF, 8'd0, 8'd0, 8'h7F);

        // Backpressure: sum held for five cycles, input blocked meanwhile.
        feed(8'd1);
        feed(8'd2);
        feed(8'd3);
        feed(8'd4);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd7;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", {31'b0, in_ready4}, 32'd0);
            check("bp_valid", {31'b0, out_valid4}, 32'd1);
            check("bp_data", {24'b0, out_data4}, 32'd10);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #1;
        check("bp_release_data", {24'b0, out_data4}, 32'd10);
        tick();
        check("bp_drained", {31'b0, out_valid4}, 32'd0);
        check("bp_busy", {31'b0, busy4}, 32'd0);

        // Full throughput: 12 ones, sums of 4 on cycles 5, 9, 13.
        for (int i = 1; i <= 13; i++) begin
            in_valid  = (i <= 12);
            in_data   = 8'd1;
            out_ready = 1'b1;
            #1;
            if (i <= 12) check("tp_in_ready", {31'b0, in_ready4}, 32'd1);
            check("tp_valid", {31'b0, out_valid4}, {31'b0, (i == 5 || i == 9 || i == 13)});
            if (out_valid4) check("tp_data", {24'b0, out_data4}, 32'd4);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("tp_end_valid", {31'b0, out_valid4}, 32'd0);

        // Partial frame with a gap, then reset discards it.
        feed(8'd9);
        in_valid = 1'b0;
        tick();
        check("gap_busy", {31'b0, busy4}, 32'd1);
        feed(8'd9);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("prst_busy", {31'b0, busy4}, 32'd0);
        check("prst_valid", {31'b0, out_valid4}, 32'd0);
        frame_expect("f8", 8'd2, 8'd2, 8'd2, 8'd2, 8'd8);

        // Stall-randomised phase on both instances from a clean reset.
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst    = 1'b0;
        m_acc4 = 8'd0;
        m_cnt4 = 0;
        n_out4 = 0;
        n_out1 = 0;
        for (int i = 0; i < 400; i++) begin
            rand_cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) begin
            rand_cycle(1'b0, 8'd0, 1'b1);
        end
        check("d4_all_delivered", q4.size(), 32'd0);
        check("d1_all_delivered", q1.size(), 32'd0);
        check("d4_some_out", {31'b0, n_out4 > 10}, 32'd1);
        check("d1_some_out", {31'b0, n_out1 > 40}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
